load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one request, runs one memory
// access (or flags an error without touching memory), and returns a one-cycle response.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign,
  output logic [1:0]        state_dbg
);

  // Handshakes: a request transfers on a rising edge where req_valid & req_ready;
  // a memory access completes on a rising edge in WAIT where mem_ready = 1;
  // rsp_valid is a single-cycle pulse with no back-pressure.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                store_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                err_q;

  logic                req_legal;
  logic                req_misaligned;
  logic                req_err;
  logic                accept;
  logic [31:0]         lane_shifted;
  logic [31:0]         load_result;
  logic [3:0]          lane_mask;
  logic [31:0]         lane_wdata;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    if (req_store) req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                               (req_funct3 == 3'b010);
    else           req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                               (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                               (req_funct3 == 3'b101);
    if (req_funct3[1:0] == 2'b01) req_misaligned = req_addr[0];
    if (req_funct3[1:0] == 2'b10) req_misaligned = (req_addr[1:0] != 2'b00);
    req_err = !req_legal || req_misaligned;
  end

  // Loaded byte/half is first moved down to bit 0, then extended.
  always_comb begin
    lane_shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    load_result  = mem_rdata;
    case (funct3_q)
      3'b000:  load_result = {{24{lane_shifted[7]}}, lane_shifted[7:0]};
      3'b001:  load_result = {{16{lane_shifted[15]}}, lane_shifted[15:0]};
      3'b100:  load_result = {24'd0, lane_shifted[7:0]};
      3'b101:  load_result = {16'd0, lane_shifted[15:0]};
      default: load_result = mem_rdata;
    endcase
  end

  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_mask  = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_mask  = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_err ? RESP : WAIT;
      WAIT:    if (mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= req_store;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err_q    <= req_err;
        if (req_err) rdata_q <= 32'd0;
      end
      if ((state_q == WAIT) && mem_ready) rdata_q <= store_q ? 32'd0 : load_result;
    end
  end

  // Memory outputs are decoded from state so an async reset drops them at once.
  assign mem_req   = (state_q == WAIT);
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? lane_wdata : 32'd0;
  assign mem_wmask = mem_we ? lane_mask : 4'b0000;

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state_q == RESP);
  assign misalign  = rsp_valid && err_q;
  assign rsp_rdata = rdata_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized requests,
// checked against a size/lane arithmetic reference model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic [1:0]  state_dbg;

  int          n_checks;
  int          n_fail;
  logic [31:0] last_rsp;
  logic [31:0] exp_q[$];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .misalign(misalign),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic bit m_err(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    size = 1 << int'(f3 % 4);
    return (a % size) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = 1 << int'(f3 % 4);
    return 4'(((1 << size) - 1) << int'(a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return (d % 256) * 32'h01010101;
    if (f3 == 3'd1) return (d % 65536) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) % 256;
    h = (w >> (8 * (a % 4))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // driver: one full request, checked cycle by cycle
  task automatic do_req(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int delay, input logic [31:0] word);
    bit          err;
    logic [31:0] exp_rsp;
    err = m_err(st, f3, a);
    @(negedge clk);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
    chk("idle_mem_addr", mem_addr, 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);
    chk("idle_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle_misalign", {31'd0, misalign}, 32'd0);
    chk("held_rsp_rdata", rsp_rdata, exp_q.size() > 0 ? exp_q.pop_front() : last_rsp);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    mem_ready  = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (err) begin
      mem_ready = 1'($urandom_range(0, 1));
      exp_rsp   = 32'd0;
    end else begin
      exp_rsp = st ? 32'd0 : m_load(f3, a, word);
      for (int k = 0; k <= delay; k++) begin
        if (k > 0) #1;
        mem_ready = (k == delay);
        mem_rdata = (k == delay) ? word : $urandom;
        @(negedge clk);
        chk("wait_mem_req", {31'd0, mem_req}, 32'd1);
        chk("wait_busy", {31'd0, busy}, 32'd1);
        chk("wait_ready", {31'd0, req_ready}, 32'd0);
        chk("wait_mem_we", {31'd0, mem_we}, {31'd0, st});
        chk("wait_mem_addr", mem_addr, a & ~32'd3);
        chk("wait_mem_wmask", {28'd0, mem_wmask}, st ? {28'd0, m_mask(f3, a)} : 32'd0);
        chk("wait_mem_wdata", mem_wdata, st ? m_wdata(f3, d) : 32'd0);
        chk("wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
      end
      #1;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_misalign", {31'd0, misalign}, {31'd0, err});
    chk("rsp_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rsp_rdata", rsp_rdata, exp_rsp);
    last_rsp = exp_rsp;
    @(posedge clk);
    #1;
  endtask

  logic [2:0]  r_f3;
  logic [31:0] r_addr;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    last_rsp   = 32'd0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ready  = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;

    // reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // directed scenarios
    do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    do_req(1'b0, 3'd0, 32'h103, 32'h0, 0, 32'h80FF1234);
    chk("lb_value", last_rsp, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h103, 32'h0, 1, 32'h80FF1234);
    chk("lbu_value", last_rsp, 32'h00000080);
    do_req(1'b1, 3'd1, 32'h102, 32'h0000ABCD, 0, 32'h0);
    do_req(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd1, 32'h200, 32'h0, 3, 32'h8001_7FFE);
    do_req(1'b0, 3'd5, 32'h202, 32'h0, 0, 32'h8001_7FFE);
    do_req(1'b1, 3'd4, 32'h200, 32'h12345678, 0, 32'h0);
    do_req(1'b0, 3'd3, 32'h200, 32'h0, 0, 32'h0);
    do_req(1'b0, 3'd5, 32'h203, 32'h0, 0, 32'h0);

    // reset pulled low mid-WAIT
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h300;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    chk("arst_pre_mem_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 mem_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_rsp = 32'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("arst_idle", {31'd0, req_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 3'd2, 32'h300, 32'h0, 1, 32'hCAFEF00D);

    // randomized requests
    for (int i = 0; i < 60; i++) begin
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = ($urandom & ~32'd3) | 32'($urandom_range(0, 3));
      if (i % 3 == 0) r_f3 = 3'($urandom_range(0, 2));
      do_req(1'($urandom_range(0, 1)), r_f3, r_addr, $urandom,
             int'($urandom_range(0, 3)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
